// File: rtl/joy_md6_pkg.sv
// Shared constants for the Mega Drive pad responder: button bit positions,
// select-sequence phase values and the default sequence inactivity timeout.
package joy_md6_pkg;

    // Bit positions in the active-high button word {M,S,Z,Y,X,C,B,A,U,D,L,R}
    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_D = 2;
    localparam int BTN_U = 3;
    localparam int BTN_A = 4;
    localparam int BTN_B = 5;
    localparam int BTN_C = 6;
    localparam int BTN_X = 7;
    localparam int BTN_Y = 8;
    localparam int BTN_Z = 9;
    localparam int BTN_S = 10;
    localparam int BTN_M = 11;

    localparam logic [2:0] PH_ID     = 3'd3;
    localparam logic [2:0] PH_EXT_LO = 3'd4;
    localparam logic [2:0] PH_MAX    = 3'd5;

    // 1.5 ms of SELECT silence at 48 MHz
    localparam int unsigned TIMEOUT_CYC_DEF = 72000;

endpackage

// File: rtl/joy_md6_pad_sel_sync.sv
// Two-flop synchronizer for the console SELECT pin with rise/fall pulses.
// Latency: 2 clocks to sel_sync; edge pulses are valid in the cycle sel_sync changes.
module joy_sel_sync (
    input  logic clk,
    input  logic reset,
    input  logic sel_async,
    output logic sel_sync,
    output logic sel_rise,
    output logic sel_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = sel_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Everything resets high so an idle-high SELECT produces no edge at release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sel_sync = sync_q;
    assign sel_rise = sync_q & ~prev_q;
    assign sel_fall = ~sync_q & prev_q;

endmodule

// File: rtl/joy_md6_pad.sv
// Mega Drive pad emulation: tracks SELECT pulses and drives the active-low DB9 data pins.
// Six-button sequencing is built only when JOY_MD6_SIX_BUTTON_EN is defined; otherwise a 3-button pad.
module joy_md6_pad
    import joy_md6_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [11:0] buttons,
    output logic [5:0]  data,
    output logic [2:0]  phase,
    output logic        ext_active
);

    logic       sel_s;
    logic       sel_rise;
    logic       sel_fall;
    logic [2:0] ph;
    logic [5:0] data_q, data_d;
    logic       ext_q, ext_d;

    joy_sel_sync u_sel_sync (
        .clk       (clk),
        .reset     (reset),
        .sel_async (sel),
        .sel_sync  (sel_s),
        .sel_rise  (sel_rise),
        .sel_fall  (sel_fall)
    );

`ifdef JOY_MD6_SIX_BUTTON_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [2:0]        phase_q, phase_d;
    logic              timeout;

    // A timeout and a falling edge together leave phase at 1: clear first, then count
    always_comb begin
        timeout = (idle_q == IDLE_MAX);
        idle_d  = idle_q;
        if (sel_rise || sel_fall) begin
            idle_d = '0;
        end else if (!timeout) begin
            idle_d = idle_q + 1'b1;
        end
        phase_d = timeout ? 3'd0 : phase_q;
        if (sel_fall && (phase_d != PH_MAX)) begin
            phase_d = phase_d + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q  <= '0;
            phase_q <= 3'd0;
        end else begin
            idle_q  <= idle_d;
            phase_q <= phase_d;
        end
    end

    assign ph = phase_q;
`else
    logic cfg_unused;

    assign ph         = 3'd0;
    assign cfg_unused = &{1'b0, sel_rise, sel_fall, buttons[BTN_X], buttons[BTN_Y],
                          buttons[BTN_Z], buttons[BTN_M], (TIMEOUT_CYC != 0)};
`endif

    always_comb begin
        ext_d = 1'b0;
        if (sel_s) begin
            if (ph == PH_ID) begin
                data_d = ~{buttons[BTN_C], buttons[BTN_B], buttons[BTN_M],
                           buttons[BTN_X], buttons[BTN_Y], buttons[BTN_Z]};
                ext_d  = 1'b1;
            end else begin
                data_d = ~{buttons[BTN_C], buttons[BTN_B], buttons[BTN_R],
                           buttons[BTN_L], buttons[BTN_D], buttons[BTN_U]};
            end
        end else if (ph == PH_ID) begin
            data_d = {~buttons[BTN_S], ~buttons[BTN_A], 4'b0000};
        end else if (ph == PH_EXT_LO) begin
            data_d = {~buttons[BTN_S], ~buttons[BTN_A], 4'b1111};
        end else begin
            data_d = {~buttons[BTN_S], ~buttons[BTN_A], 2'b00,
                      ~buttons[BTN_D], ~buttons[BTN_U]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= 6'h3F;
            ext_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ext_q  <= ext_d;
        end
    end

    assign data       = data_q;
    assign ext_active = ext_q;
    assign phase      = ph;

endmodule

// File: tb/tb_joy_md6_pad.sv
// Bench for joy_md6_pad: directed sequences plus random SELECT/button traffic against a pin-map model.
`timescale 1ns/1ps
module tb_joy_md6_pad;

    localparam int TMO = 3000;
`ifdef JOY_MD6_SIX_BUTTON_EN
    localparam bit SIX = 1'b1;
`else
    localparam bit SIX = 1'b0;
`endif
    localparam int R = 0, L = 1, D = 2, U = 3, A = 4, B = 5;
    localparam int C = 6, X = 7, Y = 8, Z = 9, S = 10, M = 11;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [11:0] buttons;
    logic [5:0]  data;
    logic [2:0]  phase;
    logic        ext_active;

    int   checks;
    int   failures;
    int   falls;
    int   hold;
    logic sel_m;

    joy_md6_pad #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .buttons    (buttons),
        .data       (data),
        .phase      (phase),
        .ext_active (ext_active)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pin levels from the pad pinout: a 1 in "low" means that pin is driven to 0
    function automatic logic [5:0] model_data(input logic s, input int ph, input logic [11:0] b);
        logic [5:0] low;
        if (s) begin
            if (ph == 3) low = {b[C], b[B], b[M], b[X], b[Y], b[Z]};
            else         low = {b[C], b[B], b[R], b[L], b[D], b[U]};
        end else if (ph == 3) begin
            low = {b[S], b[A], 4'b1111};
        end else if (ph == 4) begin
            low = {b[S], b[A], 4'b0000};
        end else begin
            low = {b[S], b[A], 2'b11, b[D], b[U]};
        end
        return ~low;
    endfunction

    function automatic int model_phase();
        if (!SIX) return 0;
        if (hold > TMO + 4) return 0;
        return falls;
    endfunction

    task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int   ph;
        logic e;
        ph = model_phase();
        e  = SIX && sel_m && (ph == 3);
        check({tag, "_data"}, data, model_data(sel_m, ph, buttons));
        check({tag, "_phase"}, {3'b000, phase}, 6'(ph));
        check({tag, "_ext"}, {5'b00000, ext_active}, {5'b00000, e});
    endtask

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
        hold += n;
    endtask

    task automatic set_sel(input logic v);
        if (v !== sel_m) begin
            if (hold > TMO) falls = 0;
            if (!v && falls < 5) falls++;
            hold  = 0;
            sel_m = v;
        end
        sel = v;
    endtask

    task automatic pulse(input int lo, input int hi);
        set_sel(1'b0);
        advance(lo);
        check_all("pulse_lo");
        set_sel(1'b1);
        advance(hi);
        check_all("pulse_hi");
    endtask

    initial begin
        int   n;
        logic v;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        sel      = 1'b1;
        sel_m    = 1'b1;
        buttons  = '0;
        falls    = 0;
        hold     = 0;

        advance(3);
        check("rst_data", data, 6'h3F);
        check("rst_phase", {3'b000, phase}, 6'd0);
        check("rst_ext", {5'b00000, ext_active}, 6'd0);
        reset = 1'b0;
        hold  = 0;
        advance(6);
        check_all("idle");

        buttons = 12'(1 << R) | 12'(1 << C);
        advance(4);
        check("rc_hi", data, 6'b010111);
        check_all("rc_hi_m");
        set_sel(1'b0);
        advance(480);
        check("rc_lo", data, 6'b110011);
        check_all("rc_lo_m");
        set_sel(1'b1);
        advance(TMO + 20);
        check_all("rc_clear");

        buttons = 12'(1 << X) | 12'(1 << M);
        pulse(480, 480);
        pulse(480, 480);
        set_sel(1'b0);
        advance(480);
        check_all("fall3");
        if (SIX) check("fall3_id", {2'b00, data[3:0]}, 6'b000000);
        else     check("fall3_noid", {2'b00, data[3:0]}, 6'b000011);
        set_sel(1'b1);
        advance(480);
        check_all("ext_hi");
        if (SIX) check("ext_word", data, 6'b110011);
        check("ext_flag", {5'b00000, ext_active}, {5'b00000, SIX});
        set_sel(1'b0);
        advance(480);
        check_all("fall4");
        if (SIX) check("fall4_ones", {2'b00, data[3:0]}, 6'b001111);
        set_sel(1'b1);
        advance(TMO + 20);
        check_all("seq_clear");

        buttons = 12'h0A5;
        pulse(50, 50);
        set_sel(1'b0);
        advance(TMO - 10);
        check_all("pre_tmo");
        advance(20);
        check_all("post_tmo");
        check("tmo_phase", {3'b000, phase}, 6'd0);
        set_sel(1'b1);
        advance(50);
        pulse(50, 50);
        pulse(50, 50);
        set_sel(1'b0);
        advance(50);
        check_all("tmo_id");
        if (SIX) check("tmo_id_nib", {2'b00, data[3:0]}, 6'b000000);

        set_sel(1'b1);
        advance(50);
        check_all("pre_rst");
        #2 reset = 1'b1;
        #1;
        check("arst_phase", {3'b000, phase}, 6'd0);
        check("arst_data", data, 6'h3F);
        check("arst_ext", {5'b00000, ext_active}, 6'd0);
        @(negedge clk);
        reset = 1'b0;
        falls = 0;
        hold  = 0;
        advance(5);
        check_all("after_arst");

        for (int i = 0; i < 200; i++) begin
            buttons = 12'($urandom);
            v = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 29) == 0) ? TMO + 20 : int'($urandom_range(5, 40));
            set_sel(v);
            advance(n);
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/joy_md6_pad.md
# joy_md6_pad

Device-side emulation of a Mega Drive 3/6-button pad on the DB9 user-port pins. It samples the console's SELECT line, tracks the 6-button select-pulse sequence with an inactivity timeout, and drives the six active-low data pins from a 12-bit active-high button word in the core's joystick layout. It is the responder for the DB9MD pad reader: it lets a core act as the pad, and gives the reader a bench-grade counterpart.

## Interface
- TIMEOUT_CYC, 72000: idle clocks after the last SELECT edge before the sequence counter clears (1.5 ms at 48 MHz).
- clk  in  1  system clock (48 MHz).
- reset  in  1  asynchronous, active-high.
- sel  in  1  console SELECT pin, asynchronous to clk.
- buttons  in  12  active-high, bit order {M,S,Z,Y,X,C,B,A,U,D,L,R} (bit0 = Right).
- data  out  6  pad pins D5..D0, active-low levels.
- phase  out  3  current sequence count, for debug.
- ext_active  out  1  high while data carries the extended (X/Y/Z/Mode) word.

## Operation
- sel passes through a 2-FF synchronizer. The synchronizer resets to 1. Rising and falling edges are detected on the synchronized value.
- phase (0..5) increments on each falling edge and saturates at 5.
- idle counter:
  - Clears on any edge.
  - Counts otherwise and saturates at TIMEOUT_CYC-1.
  - On reaching TIMEOUT_CYC-1, phase clears to 0.
- If a timeout and a falling edge occur in the same cycle, phase becomes 1 (the clear applies first, then the edge counts).
- Output map, written as D5..D0, where a pressed button drives its pin 0:
  - sel=1, phase≠3: {C, B, R, L, D, U}.
  - sel=1, phase=3: {C, B, M, X, Y, Z}; ext_active=1.
  - sel=0, phase=3: {S, A, 0, 0, 0, 0}. This is the 6-button ID.
  - sel=0, phase=4: {S, A, 1, 1, 1, 1}.
  - sel=0, other phase: {S, A, 0, 0, D, U}.
- buttons are sampled in the clk domain with no synchronization. The caller supplies them in this domain.

## Timing
- data, ext_active and phase are registered.
- A change on the sel pin reaches data 3 clocks later: 2 sync stages plus 1 output register.
- A change on buttons reaches data 1 clock later.
- Reset values:
  - sync = 1
  - phase = 0
  - idle counter = 0
  - data = 6'h3F
  - ext_active = 0
- Reset asserted mid-sequence returns phase to 0 immediately (asynchronously). The next sequence starts at the normal map.
- A continuously pulsing sel never times out. phase sits at 5 and the normal map repeats.
- A glitch shorter than 1 clock may be missed by the synchronizer. This is acceptable.

## Configuration
- JOY_MD6_SIX_BUTTON_EN defined: full 6-button behaviour as above.
- Undefined: the block is a 3-button pad.
  - phase and the idle counter are not built.
  - phase output is tied to 0 and ext_active is tied to 0.
  - data always uses the normal sel=1 / sel=0 maps.
  - TIMEOUT_CYC is ignored.

## Structure
- Package joy_md6_pkg holds:
  - button bit index constants (BTN_R..BTN_M);
  - phase localparams (PH_ID=3, PH_EXT_LO=4, PH_MAX=5);
  - default TIMEOUT_CYC.
- Sub-module joy_sel_sync holds the 2-FF synchronizer plus rise/fall pulse outputs. Its reset value is 1.
- The top level holds the phase/idle logic and the output mux/register.

## Test plan
- After reset with buttons=0, sel held at 1 → data=6'h3F, phase=0, ext_active=0.
- buttons={R,C} pressed, sel=1 → data=6'b0_1_0_1_1_1. Then sel=0 → data=6'b1_1_0_0_1_1.
- Three sel 1→0→1 cycles (10 µs per level), then a fourth low, with X and Mode pressed:
  - after the 3rd fall: data[3:0]=0000;
  - on the next high: data=6'b1_1_0_0_1_1 with ext_active=1;
  - after the 4th fall: data[3:0]=1111.
- Two falls, then sel idle for 72000 clocks → phase returns to 0 in the next cycle. The next three falls again produce the ID word.
- Assert reset while phase=3 → phase=0 and data=6'h3F with no clock edge required.
- Build without JOY_MD6_SIX_BUTTON_EN and repeat the 3-cycle sequence → no 0000 ID word appears and ext_active stays 0.
